// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-only data memory: sub-word stores by read-modify-write,
// sign/zero-extended loads. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W into faults.
module lsu_mem_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = 32'h02000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                r_state, w_nxt;
  logic                  r_we, r_err;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic [15:0]           r_wdata;
  logic [DATA_WIDTH-1:0] r_word, r_wr_data;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic                  w_accept, w_fault, w_misalign;
  logic [1:0]            w_off;
  logic [DATA_WIDTH-1:0] w_merge, w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = (req_addr < DMEM_BASE) ||
                   (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_we && req_funct3[2]) || w_misalign;

  // Effective lane offset; misaligned low bits are dropped when not trapping.
  always_comb begin
    w_off = 2'b00;
    case (req_funct3[1:0])
      2'b00:   w_off = req_addr[1:0];
      2'b01:   w_off = {req_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)
                w_nxt = (!w_fault && req_we && (req_funct3[1:0] == 2'b10)) ? S_WR : S_RD;
      // A faulting request spends its RD cycle idle so it keeps the 2-cycle latency.
      S_RD:   w_nxt = (r_we && !r_err) ? S_WR : S_RESP;
      S_WR:   w_nxt = S_RESP;
      S_RESP: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_merge = mem_rd_data;
    if (r_f3[1:0] == 2'b00) w_merge[{r_off, 3'b000} +: 8]        = r_wdata[7:0];
    else                    w_merge[{r_off[1], 4'b0000} +: 16]   = r_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_f3       <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_wr_data  <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_off   <= w_off;
        r_wdata <= req_wdata[15:0];
        r_err   <= w_fault;
        if (!w_fault) r_mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (!w_fault && req_we) r_wr_data <= req_wdata;
      end
      if (r_state == S_RD && !r_err) begin
        r_word <= mem_rd_data;
        if (r_we) r_wr_data <= w_merge;
      end
    end
  end

  assign w_byte = r_word[{r_off, 3'b000} +: 8];
  assign w_half = r_word[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = r_word;
    case (r_f3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = r_word;
    endcase
  end

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_err    = resp_valid && r_err;
  assign resp_rdata  = (resp_valid && !r_err && !r_we) ? w_load : '0;
  assign mem_wr_en   = (r_state == S_WR);
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_wr_data;

endmodule
